// File: rtl/mem_req_pkg.sv
// Shared types for the 16-word memory request master: FSM encoding, command and response payloads.
package mem_req_pkg;

   localparam int unsigned MEM_ADDR_W = 4;
   localparam int unsigned MEM_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2
   } state_e;

   typedef struct packed {
      logic                  rnw;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
   } mem_cmd_t;

   typedef struct packed {
      logic [MEM_DATA_W-1:0] rdata;
      logic                  err;
   } mem_rsp_t;

   // Watchdog counter width; a disabled watchdog still gets one bit so the register exists.
   function automatic int unsigned wdog_width(input int unsigned timeout);
      return (timeout == 0) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mem_cmd_fifo.sv
// In-order command buffer; an extra pointer bit separates full from empty.
module mem_cmd_fifo
   import mem_req_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic     clk,
   input  logic     reset_n,
   input  logic     i_push,
   input  mem_cmd_t i_cmd,
   input  logic     i_pop,
   output mem_cmd_t o_head,
   output logic     o_full,
   output logic     o_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W:0] r_wr_ptr;
   logic [PTR_W:0] r_rd_ptr;
   mem_cmd_t       r_mem [DEPTH];
   logic           w_push;
   logic           w_pop;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
      end
   end

   // Storage needs no reset: the head is only consumed while non-empty.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_cmd;
   end

endmodule

// File: rtl/mem_req_master.sv
// Upstream master: queues commands, runs one memory req/ready transaction at a time
// with a watchdog, and returns one in-order response per command.
module mem_req_master
   import mem_req_pkg::*;
#(
   parameter int unsigned ADDR_W     = MEM_ADDR_W,
   parameter int unsigned DATA_W     = MEM_DATA_W,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_rnw_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   output logic              req_o,
   output logic              req_rnw_o,
   output logic [ADDR_W-1:0] req_addr_o,
   output logic [DATA_W-1:0] req_wdata_o,
   input  logic              req_ready_i,
   input  logic [DATA_W-1:0] req_rdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              busy_o
);

   localparam int unsigned      CNT_W     = wdog_width(TIMEOUT);
   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] WDOG_MAX  = '1;
   localparam logic [1:0]       S_IDLE    = ST_IDLE;
   localparam logic [1:0]       S_REQ     = ST_REQ;
   localparam logic [1:0]       S_RSP     = ST_RSP;

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   mem_cmd_t         r_issue;
   mem_rsp_t         r_rsp;
   mem_rsp_t         w_rsp_next;
   logic [CNT_W-1:0] r_wdog;
   logic [CNT_W-1:0] w_wdog_next;
   logic             r_req;
   logic             r_rsp_valid;
   logic             w_pop;
   logic             w_capture;
   logic             w_push;
   mem_cmd_t         w_push_cmd;
   mem_cmd_t         w_head;
   logic             w_full;
   logic             w_empty;

   assign w_push           = cmd_valid_i && !w_full;
   assign w_push_cmd.rnw   = cmd_rnw_i;
   assign w_push_cmd.addr  = MEM_ADDR_W'(cmd_addr_i);
   assign w_push_cmd.wdata = MEM_DATA_W'(cmd_wdata_i);

   mem_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_cmd   (w_push_cmd),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   // Next state, FIFO pop, response capture and watchdog update.
   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      w_capture    = 1'b0;
      w_rsp_next   = r_rsp;
      w_wdog_next  = r_wdog;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_wdog_next  = '0;
               w_next_state = S_REQ;
            end
         end
         S_REQ: begin
            // Memory ready wins over a timeout landing in the same cycle.
            if (req_ready_i) begin
               w_capture        = 1'b1;
               w_rsp_next.rdata = r_issue.rnw ? MEM_DATA_W'(req_rdata_i) : '0;
               w_rsp_next.err   = 1'b0;
               w_next_state     = S_RSP;
            end else if ((TIMEOUT != 0) && (r_wdog == WDOG_LAST)) begin
               w_capture        = 1'b1;
               w_rsp_next.rdata = '0;
               w_rsp_next.err   = 1'b1;
               w_next_state     = S_RSP;
            end else if (r_wdog != WDOG_MAX) begin
               w_wdog_next = r_wdog + CNT_W'(1);
            end
         end
         S_RSP: begin
            if (rsp_ready_i) begin
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_wdog_next  = '0;
                  w_next_state = S_REQ;
               end else begin
                  w_next_state = S_IDLE;
               end
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Issue, response and watchdog registers plus registered handshake outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_issue     <= '0;
         r_rsp       <= '0;
         r_wdog      <= '0;
         r_req       <= 1'b0;
         r_rsp_valid <= 1'b0;
      end else begin
         if (w_pop)     r_issue <= w_head;
         if (w_capture) r_rsp   <= w_rsp_next;
         r_wdog      <= w_wdog_next;
         r_req       <= (w_next_state == S_REQ);
         r_rsp_valid <= (w_next_state == S_RSP);
      end
   end

   assign cmd_ready_o = !w_full;
   assign req_o       = r_req;
   assign req_rnw_o   = r_issue.rnw;
   assign req_addr_o  = ADDR_W'(r_issue.addr);
   assign req_wdata_o = DATA_W'(r_issue.wdata);
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_rdata_o = DATA_W'(r_rsp.rdata);
   assign rsp_err_o   = r_rsp.err;
   assign busy_o      = !w_empty || (r_state != S_IDLE);

endmodule

// File: doc/mem_req_master.md
# mem_req_master

Upstream request master for the simple 16-word memory interface. Accepts memory commands on a valid/ready stream, buffers them in a small in-order FIFO, and drives the memory's `req`/`ready` handshake one transaction at a time. It returns one response per command (read data or error) on a valid/ready response stream. A watchdog aborts any request the memory never acknowledges.

## Interface
- `ADDR_W`, default 4: memory word address width.
- `DATA_W`, default 32: data width.
- `FIFO_DEPTH`, default 4: command FIFO entries; must be a power of two, ≥2.
- `TIMEOUT`, default 15: maximum cycles `req_o` stays high without `req_ready_i`; 0 disables the watchdog.

- `clk`  in  1  clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid_i`  in  1  command offered.
- `cmd_ready_o`  out  1  command accepted when high with `cmd_valid_i`.
- `cmd_rnw_i`  in  1  1 = read, 0 = write.
- `cmd_addr_i`  in  ADDR_W  word address.
- `cmd_wdata_i`  in  DATA_W  write data (ignored for reads).
- `req_o`  out  1  request to memory.
- `req_rnw_o`  out  1  request direction.
- `req_addr_o`  out  ADDR_W  request address.
- `req_wdata_o`  out  DATA_W  request write data.
- `req_ready_i`  in  1  memory completes the transaction this cycle.
- `req_rdata_i`  in  DATA_W  read data; valid when `req_ready_i` is high on a read.
- `rsp_valid_o`  out  1  response available.
- `rsp_ready_i`  in  1  response consumed when high with `rsp_valid_o`.
- `rsp_rdata_o`  out  DATA_W  read data; 0 for writes and errors.
- `rsp_err_o`  out  1  transaction timed out.
- `busy_o`  out  1  FIFO non-empty, or state not IDLE.

## Operation
- **Command FIFO.** Push on `cmd_valid_i && cmd_ready_o`. `cmd_ready_o = !full`; a full FIFO does not accept, even if a pop happens in the same cycle. Push and pop in the same cycle are legal when not full. Pointers wrap modulo `FIFO_DEPTH`; an extra pointer bit distinguishes full from empty.
- **FSM states:** IDLE, REQ, RSP.
  - **IDLE.** If the FIFO is non-empty: pop the head into the issue register, clear the watchdog counter, go to REQ.
  - **REQ.** `req_o` = 1, and `req_rnw_o`/`req_addr_o`/`req_wdata_o` are held constant from the issue register.
    - If `req_ready_i`: capture the response (`rdata` = `req_rdata_i` for a read, 0 for a write; `err` = 0), go to RSP.
    - Else, if `TIMEOUT` ≠ 0 and this is the `TIMEOUT`-th REQ cycle: capture `rdata` = 0, `err` = 1, go to RSP.
    - Else increment the counter.
    - If `req_ready_i` arrives in the final watchdog cycle, ready wins and the response is a success.
  - **RSP.** `rsp_valid_o` = 1; `rsp_rdata_o`/`rsp_err_o` are stable. On `rsp_ready_i`:
    - if the FIFO is non-empty, pop the next command and go directly to REQ (no IDLE bubble);
    - otherwise go to IDLE.
- Responses are returned strictly in command order, one per accepted command.
- `req_*` field outputs keep their last value outside REQ; only `req_o` qualifies them.
- Watchdog counter width is `$clog2(TIMEOUT+1)`; it saturates and never wraps.

## Timing
- **Reset (`reset_n` low), asynchronous:**
  - FIFO emptied, state IDLE, counter 0.
  - `req_o`, `rsp_valid_o`, `rsp_err_o`, `busy_o` = 0.
  - `req_rnw_o`, `req_addr_o`, `req_wdata_o`, `rsp_rdata_o` = 0.
  - `cmd_ready_o` = 1, since the FIFO is empty.
- **Reset mid-operation:** an in-flight request is dropped immediately (`req_o` falls without waiting for the clock). Queued commands and a pending response are discarded; no response is produced for them after release.
- **Latency, empty design:** command accepted at edge E0 → `req_o` high after E1. Memory ready in the first REQ cycle → `rsp_valid_o` high after E2.
- **Throughput:** with immediate memory ready and `rsp_ready_i` held high, one transaction every 2 cycles (REQ, RSP alternating).
- `req_o` never drops before `req_ready_i` or a timeout. `rsp_valid_o` never drops before `rsp_ready_i`.

## Structure
- Shared package `mem_req_pkg` holds:
  - `state_e` enum: IDLE, REQ, RSP;
  - `mem_cmd_t` struct: `rnw`, `addr`, `wdata`;
  - `mem_rsp_t` struct: `rdata`, `err`.
- Sub-module `mem_cmd_fifo`: parameterised synchronous FIFO of `mem_cmd_t`, with `full`/`empty` outputs and the same async active-low reset.
- Top level contains the FSM, issue register, watchdog counter and response register.

## Test plan
- **Single write.** Write addr 4'h3, data 32'hDEAD_BEEF; memory asserts ready on the 3rd REQ cycle → `req_o` high exactly 3 cycles with fields stable; response `err` = 0, `rdata` = 0.
- **Write then read.** Write 4'h3/32'hDEAD_BEEF, then read 4'h3 → read response `rsp_rdata_o` = 32'hDEAD_BEEF, `err` = 0, in order.
- **Backpressure.** `rsp_ready_i` = 0, immediate memory ready, offer 6 back-to-back commands → 5 accepted (1 issued, 4 queued), `cmd_ready_o` low on the 6th. After `rsp_ready_i` = 1, 5 responses in order; the 6th is then accepted.
- **Timeout.** `TIMEOUT` = 15, `req_ready_i` held 0 → `req_o` high exactly 15 cycles, then response `err` = 1, `rdata` = 0. The next queued command issues normally.
- **Ready in final watchdog cycle.** `req_ready_i` pulses in REQ cycle 15 on a read with memory data 32'h1234_5678 → `err` = 0, `rdata` = 32'h1234_5678.
- **Reset mid-REQ.** Three commands queued, reset pulsed during REQ → `req_o`, `rsp_valid_o` = 0 immediately; `cmd_ready_o` = 1; no responses after release; `busy_o` = 0.
